// File: rtl/node_compare_sched.sv
// Scans N latched neighbour values through one shared external comparator,
// one per clock, and ORs the enabled results. Option: NODE_SCHED_EARLY_EXIT_EN.
module node_compare_sched #(
  parameter int W    = 2,
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    in,
  input  logic [N*W-1:0]  nbr,
  input  logic [N-1:0]    nbr_en,
  output logic [W-1:0]    cmp_a,
  output logic [W-1:0]    cmp_b,
  input  logic            cmp_y,
  output logic            busy,
  output logic            done,
  output logic            out,
  output logic [N-1:0]    hit_mask,
  output logic [IDXW-1:0] cur_idx
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t         state, state_nxt;
  logic [N*W-1:0] nbr_q;
  logic [N-1:0]   en_q;
  logic           acc;
  logic           hit;
  logic           last;

  assign hit  = cmp_y & en_q[cur_idx];
  assign last = (cur_idx == IDXW'(N - 1));
  assign busy = (state == CMP);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CMP;
      CMP: begin
        if (last) state_nxt = DONE;
`ifdef NODE_SCHED_EARLY_EXIT_EN
        if (hit) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmp_b is preloaded one index ahead so the selected neighbour is on the
  // comparator in the same cycle cur_idx points at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      nbr_q    <= '0;
      en_q     <= '0;
      acc      <= 1'b0;
      out      <= 1'b0;
      hit_mask <= '0;
      cur_idx  <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nbr_q    <= nbr;
            en_q     <= nbr_en;
            cmp_a    <= in;
            cmp_b    <= nbr[W-1:0];
            cur_idx  <= '0;
            acc      <= 1'b0;
            hit_mask <= '0;
          end
        end
        CMP: begin
          hit_mask[cur_idx] <= hit;
          acc               <= acc | hit;
          if (state_nxt == DONE) begin
            out <= acc | hit;
          end else begin
            cur_idx <= cur_idx + IDXW'(1);
            cmp_b   <= nbr_q[(int'(cur_idx) + 1) * W +: W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_node_compare_sched.sv
// Directed bench for node_compare_sched with a behavioural a>b comparator.
module tb_node_compare_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] in_v;
  logic [7:0] nbr_v;
  logic [3:0] en_v;
  logic [1:0] cmp_a, cmp_b;
  logic       cmp_y;
  logic       busy, done, out;
  logic [3:0] hit_mask;
  logic [1:0] cur_idx;

  int   errors = 0;
  int   checks = 0;
  logic last_out = 1'b0;

  always #5 clk = ~clk;

  assign cmp_y = (cmp_a > cmp_b);

  node_compare_sched #(.W(2), .N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in_v), .nbr(nbr_v), .nbr_en(en_v),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_y(cmp_y), .busy(busy), .done(done),
    .out(out), .hit_mask(hit_mask), .cur_idx(cur_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse, scrambles the inputs afterwards, and follows the scan.
  task automatic run_scan(input string tag, input logic [1:0] a, input logic [7:0] nv,
                          input logic [3:0] ev, input logic exp_out,
                          input logic [3:0] exp_mask, input int exp_lat);
    int k;
    in_v = a; nbr_v = nv; en_v = ev; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_v = 2'd0; nbr_v = 8'hFF; en_v = 4'h0;
    check({tag, " mask_cleared"}, hit_mask, 4'h0);
    check({tag, " out_held_at_start"}, out, last_out);
    k = 0;
    while (done !== 1'b1 && k < 8) begin
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " cur_idx"}, cur_idx, k[1:0]);
      check({tag, " cmp_a"}, cmp_a, a);
      check({tag, " cmp_b"}, cmp_b, nv[k[1:0]*2 +: 2]);
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, exp_lat);
    check({tag, " out"}, out, exp_out);
    check({tag, " hit_mask"}, hit_mask, exp_mask);
    check({tag, " busy_in_done"}, busy, 1'b0);
    last_out = exp_out;
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " out_hold"}, out, exp_out);
    check({tag, " mask_hold"}, hit_mask, exp_mask);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_v = 2'd0; nbr_v = 8'h00; en_v = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out", out, 1'b0);
    check("rst hit_mask", hit_mask, 4'h0);
    check("rst cur_idx", cur_idx, 2'd0);
    check("rst cmp_a", cmp_a, 2'd0);
    check("rst cmp_b", cmp_b, 2'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef NODE_SCHED_EARLY_EXIT_EN
    // nbr j0..j3 = {3,1,0,0}; first hit at j1 ends the scan
    run_scan("early_exit", 2'd2, 8'h07, 4'hF, 1'b1, 4'b0010, 2);
`else
    run_scan("all_equal", 2'd3, 8'hFF, 4'hF, 1'b0, 4'h0, 4);
    // nbr j0..j3 = {3,1,3,3}
    run_scan("one_hit", 2'd2, 8'hF7, 4'hF, 1'b1, 4'b0010, 4);
    run_scan("hit_masked", 2'd2, 8'hF7, 4'b1101, 1'b0, 4'h0, 4);

    // reset on the second CMP cycle discards the partial result
    in_v = 2'd3; nbr_v = 8'h00; en_v = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst pre cur_idx", cur_idx, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst out", out, 1'b0);
    check("midrst hit_mask", hit_mask, 4'h0);
    check("midrst cur_idx", cur_idx, 2'd0);
    check("midrst cmp_a", cmp_a, 2'd0);
    for (int k = 0; k < 5; k++) begin
      check("midrst no_done", done, 1'b0);
      @(negedge clk);
    end
    last_out = 1'b0;
    run_scan("after_rst", 2'd3, 8'h00, 4'hF, 1'b1, 4'hF, 4);

    // start held high: nbr j0..j3 = {0,2,2,2}, one scan per 6 cycles
    in_v = 2'd1; nbr_v = 8'hA8; en_v = 4'hF; start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check("held done", done, (k % 6) == 5);
      if ((k % 6) == 5) begin
        check("held out", out, 1'b1);
        check("held hit_mask", hit_mask, 4'b0001);
      end
    end
    start = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
